mem_access_unit: RTL and testbench

- Memory-stage load/store unit of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the memory controls, ALU address and store data produced by EX/MEM. Drives a req/ack handshake to the external data memory.
- Stalls the pipeline while an access is outstanding. Returns size-extracted, sign/zero-extended load data as readDataM for MEM/WB.
- Flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage load/store unit and external data memory.
// The unit drives request, address, byte enables and store data; memory returns
// read data together with an acknowledge.
interface mem_access_unit_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memAck;

  modport master (
    output memReq,
    output memWe,
    output memAddr,
    output memBe,
    output memWData,
    input  memRData,
    input  memAck
  );

  modport slave (
    input  memReq,
    input  memWe,
    input  memAddr,
    input  memBe,
    input  memWData,
    output memRData,
    output memAck
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one req/ack transaction per aligned load or
// store, stalls the pipeline while it is outstanding, formats store lanes,
// extracts and extends load data, and aborts accesses that exceed TIMEOUT.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [1:0]  memSizeM,
  input  logic        memUnsignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        busErrM,
  mem_access_unit_if.master mem
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        addr_bad;
  logic        access;
  logic        is_load;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [3:0]  be;
  logic [31:0] wdata;

  // Alignment check and store lane formatting, both keyed on access size.
  always_comb begin
    addr_bad = 1'b0;
    be       = 4'b1111;
    wdata    = writeDataM;
    unique case (memSizeM)
      2'b00: begin
        be    = 4'b0001 << ALUOutM[1:0];
        wdata = {4{writeDataM[7:0]}};
      end
      2'b01: begin
        addr_bad = ALUOutM[0];
        be       = ALUOutM[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{writeDataM[15:0]}};
      end
      default: addr_bad = |ALUOutM[1:0];
    endcase
  end

  assign misalignM = (memReadM | memWriteM) & addr_bad;
  assign access    = (memReadM | memWriteM) & ~addr_bad;
  // A simultaneous read and write is treated as a store.
  assign is_load   = memReadM & ~memWriteM;
  // Gated by rst so an in-flight stall drops the moment reset is applied.
  assign stallM    = ~rst & access & (state_q != StDone);

  // Lane selection and sign/zero extension of the returned word.
  always_comb begin
    load_byte = mem.memRData[7:0];
    unique case (ALUOutM[1:0])
      2'b00: load_byte = mem.memRData[7:0];
      2'b01: load_byte = mem.memRData[15:8];
      2'b10: load_byte = mem.memRData[23:16];
      2'b11: load_byte = mem.memRData[31:24];
    endcase
    load_half = ALUOutM[1] ? mem.memRData[31:16] : mem.memRData[15:0];
    unique case (memSizeM)
      2'b00:   load_data = {{24{load_byte[7] & ~memUnsignedM}}, load_byte};
      2'b01:   load_data = {{16{load_half[15] & ~memUnsignedM}}, load_half};
      default: load_data = mem.memRData;
    endcase
  end

  // Next-state logic for the access FSM and its registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    bus_err_d = bus_err_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          state_d   = StBusy;
          req_d     = 1'b1;
          we_d      = memWriteM;
          bus_err_d = 1'b0;
          cnt_d     = '0;
        end else if (misalignM) begin
          rdata_d = '0;
        end
      end
      StBusy: begin
        if (mem.memAck) begin
          state_d   = StDone;
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b0;
          if (is_load) rdata_d = load_data;
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      bus_err_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      bus_err_q <= bus_err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign readDataM    = rdata_q;
  assign busErrM      = bus_err_q;
  assign mem.memReq   = req_q;
  assign mem.memWe    = we_q;
  assign mem.memAddr  = {ALUOutM[31:2], 2'b00};
  assign mem.memBe    = be;
  assign mem.memWData = wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: acts as the data memory, pushes the expected load
// result when each access is launched and checks it when the stall releases.
module tb_mem_access_unit;

  localparam int unsigned Timeout = 4;

  logic        clk;
  logic        rst;
  logic        memReadM;
  logic        memWriteM;
  logic [1:0]  memSizeM;
  logic        memUnsignedM;
  logic [31:0] ALUOutM;
  logic [31:0] writeDataM;
  logic [31:0] readDataM;
  logic        stallM;
  logic        misalignM;
  logic        busErrM;

  mem_access_unit_if mem ();

  mem_access_unit #(
    .TIMEOUT (Timeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .memReadM     (memReadM),
    .memWriteM    (memWriteM),
    .memSizeM     (memSizeM),
    .memUnsignedM (memUnsignedM),
    .ALUOutM      (ALUOutM),
    .writeDataM   (writeDataM),
    .readDataM    (readDataM),
    .stallM       (stallM),
    .misalignM    (misalignM),
    .busErrM      (busErrM),
    .mem          (mem)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  task automatic idle_inputs();
    memReadM     = 1'b0;
    memWriteM    = 1'b0;
    memSizeM     = 2'b10;
    memUnsignedM = 1'b0;
    ALUOutM      = '0;
    writeDataM   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    mem.memAck   = 1'b0;
    mem.memRData = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (readDataM !== 32'h0 || busErrM !== 1'b0 || mem.memReq !== 1'b0 ||
        mem.memWe !== 1'b0 || stallM !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rd=%h err=%b req=%b we=%b stall=%b, required 0/0/0/0/0",
               readDataM, busErrM, mem.memReq, mem.memWe, stallM);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Launch one access (caller is 1 time unit after a rising edge), play the memory
  // side and check bus fields, stall/request lengths and the completed result.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rword,
                            input int ack_after, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                            input logic exp_err);
    int stalls;
    int reqs;
    bit done;
    bit bus_seen;
    int exp_stalls;
    int exp_reqs;
    logic [31:0] exp;
    stalls     = 0;
    reqs       = 0;
    done       = 1'b0;
    bus_seen   = 1'b0;
    exp_reqs   = (ack_after < 0) ? int'(Timeout) : ack_after + 1;
    exp_stalls = exp_reqs + 1;
    memReadM     = rd;
    memWriteM    = wr;
    memSizeM     = sz;
    memUnsignedM = uns;
    ALUOutM      = addr;
    writeDataM   = wdata;
    mem.memRData = rword;
    mem.memAck   = 1'b0;
    exp_q.push_back(exp_rd);
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (!stallM) begin
        done = 1'b1;
        exp  = exp_q.pop_front();
        n_checks++;
        if (readDataM !== exp) begin
          n_fail++;
          $display("FAIL %s readDataM: got %h, required %h", name, readDataM, exp);
        end
        n_checks++;
        if (busErrM !== exp_err || mem.memReq !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done: busErrM=%b memReq=%b, required %b/0",
                   name, busErrM, mem.memReq, exp_err);
        end
        n_checks++;
        if (stalls != exp_stalls || reqs != exp_reqs) begin
          n_fail++;
          $display("FAIL %s timing: stalls=%0d reqs=%0d, required %0d/%0d",
                   name, stalls, reqs, exp_stalls, exp_reqs);
        end
      end else begin
        stalls++;
        if (mem.memReq) begin
          reqs++;
          if (!bus_seen) begin
            bus_seen = 1'b1;
            n_checks++;
            if (mem.memWe !== wr || mem.memAddr !== (addr & 32'hFFFF_FFFC) ||
                mem.memBe !== exp_be || mem.memWData !== exp_wd) begin
              n_fail++;
              $display("FAIL %s bus: we=%b addr=%h be=%b wd=%h, required %b/%h/%b/%h",
                       name, mem.memWe, mem.memAddr, mem.memBe, mem.memWData,
                       wr, addr & 32'hFFFF_FFFC, exp_be, exp_wd);
            end
          end
          if (ack_after >= 0 && reqs == ack_after + 1) mem.memAck = 1'b1;
        end
        @(posedge clk);
        #1;
        mem.memAck = 1'b0;
      end
    end
    if (!done) begin
      void'(exp_q.pop_front());
      n_checks++;
      n_fail++;
      $display("FAIL %s stall never released: got stallM=1, required 0", name);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_loads();
    run_access("lw", 1, 0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 4'b1111, 0,
               32'hDEADBEEF, 0);
    run_access("lb", 1, 0, 2'b00, 0, 32'h13, 0, 32'h80123456, 0, 4'b1000, 0,
               32'hFFFFFF80, 0);
    run_access("lbu", 1, 0, 2'b00, 1, 32'h13, 0, 32'h80123456, 0, 4'b1000, 0,
               32'h00000080, 0);
  endtask

  task automatic test_store();
    run_access("sh", 0, 1, 2'b01, 0, 32'h22, 32'h0000ABCD, 32'hFFFFFFFF, 0, 4'b1100,
               32'hABCDABCD, 32'h00000080, 0);
  endtask

  task automatic test_misalign();
    memReadM = 1'b1;
    memSizeM = 2'b10;
    ALUOutM  = 32'h06;
    @(negedge clk);
    n_checks++;
    if (misalignM !== 1'b1 || stallM !== 1'b0 || mem.memReq !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign: misalignM=%b stallM=%b memReq=%b, required 1/0/0",
               misalignM, stallM, mem.memReq);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (readDataM !== 32'h0 || mem.memReq !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign next: readDataM=%h memReq=%b, required 0/0",
               readDataM, mem.memReq);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    run_access("lh slow", 1, 0, 2'b01, 0, 32'h22, 0, 32'h80017FFF, 2, 4'b1100, 0,
               32'hFFFF8001, 0);
    run_access("lhu", 1, 0, 2'b01, 1, 32'h20, 0, 32'h80017FFF, 0, 4'b0011, 0,
               32'h00007FFF, 0);
    run_access("lbu lane2", 1, 0, 2'b00, 1, 32'h12, 0, 32'h00AB0000, 1, 4'b0100, 0,
               32'h000000AB, 0);
    run_access("sb", 0, 1, 2'b00, 0, 32'h11, 32'h000000A5, 32'h0, 0, 4'b0010,
               32'hA5A5A5A5, 32'h000000AB, 0);
    run_access("rd+wr", 1, 1, 2'b10, 0, 32'h30, 32'h12345678, 32'hFFFFFFFF, 0, 4'b1111,
               32'h12345678, 32'h000000AB, 0);
  endtask

  task automatic test_timeout();
    run_access("timeout", 1, 0, 2'b10, 0, 32'h44, 0, 32'h55555555, -1, 4'b1111, 0,
               32'h0, 1);
    run_access("after timeout", 1, 0, 2'b10, 0, 32'h48, 0, 32'hCAFEF00D, 0, 4'b1111, 0,
               32'hCAFEF00D, 0);
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    seen     = 1'b0;
    memReadM = 1'b1;
    memSizeM = 2'b10;
    ALUOutM  = 32'h50;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      seen = mem.memReq;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reset-mid: memReq never rose, got 0, required 1");
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem.memReq !== 1'b0 || stallM !== 1'b0 || readDataM !== 32'h0) begin
      n_fail++;
      $display("FAIL reset-mid: memReq=%b stallM=%b readDataM=%h, required 0/0/0",
               mem.memReq, stallM, readDataM);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_access("lw after reset", 1, 0, 2'b10, 0, 32'h54, 0, 32'h01020304, 0, 4'b1111, 0,
               32'h01020304, 0);
  endtask

  initial begin
    clk = 1'b0;
    test_reset();
    test_loads();
    test_store();
    test_misalign();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
